// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//
// Purpose:
//   Shares one APB slave between two local requesters. Arbitration is
//   round-robin. The block sequences IDLE -> SETUP -> ACCESS on the APB pins
//   and returns read data and error status to the requester that was granted.
//   Every output is driven from a register.
//
// Ports:
//   p_clk, p_rst     clock; synchronous active-high reset
//   req_valid[1:0]   per-requester request, held until its req_ready bit
//   req_write[1:0]   per-requester direction (1 = write)
//   req_addr         requester i at [i*A_WIDTH +: A_WIDTH]
//   req_wdata        requester i at [i*D_WIDTH +: D_WIDTH]
//   req_ready[1:0]   one-cycle accept pulse (one-hot or zero)
//   rsp_valid[1:0]   one-cycle completion pulse (one-hot or zero)
//   rsp_rdata        read data (0 for writes), valid with rsp_valid
//   rsp_err          slave error or timeout, valid with rsp_valid
//   p_sel, p_enable, p_write, p_addr, wr_data   APB master outputs
//   rd_data, p_ready, p_slverr                  APB slave inputs
//
// Optional feature:
//   APB_RR_TIMEOUT_EN - when defined, an ACCESS phase that waits
//   TIMEOUT_CYCLES cycles without p_ready is aborted with rsp_err=1.
// ---------------------------------------------------------------------------
module apb_rr_master #(
    parameter int A_WIDTH        = 8,
    parameter int D_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   p_clk,
    input  logic                   p_rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [2*A_WIDTH-1:0]   req_addr,
    input  logic [2*D_WIDTH-1:0]   req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [D_WIDTH-1:0]     rsp_rdata,
    output logic                   rsp_err,
    output logic                   p_sel,
    output logic                   p_enable,
    output logic                   p_write,
    output logic [A_WIDTH-1:0]     p_addr,
    output logic [D_WIDTH-1:0]     wr_data,
    input  logic [D_WIDTH-1:0]     rd_data,
    input  logic                   p_ready,
    input  logic                   p_slverr
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("apb_rr_master: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t               r_state,     w_nextState;
    logic                 r_lastGnt,   w_nextLastGnt;
    logic [1:0]           r_reqReady,  w_reqReady;
    logic [1:0]           r_rspValid,  w_rspValid;
    logic [D_WIDTH-1:0]   r_rspRdata,  w_rspRdata;
    logic                 r_rspErr,    w_rspErr;
    logic                 r_pSel,      w_pSel;
    logic                 r_pEnable,   w_pEnable;
    logic                 r_pWrite,    w_pWrite;
    logic [A_WIDTH-1:0]   r_pAddr,     w_pAddr;
    logic [D_WIDTH-1:0]   r_wrData,    w_wrData;
    logic                 w_win;

`ifdef APB_RR_TIMEOUT_EN
    // The abort fires in the ACCESS cycle that completes the wait budget,
    // i.e. when the count of earlier waiting cycles is TIMEOUT_CYCLES-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]           r_toCnt,     w_toCnt;
`endif

    // State and output registers; the reset pointer of 1 lets requester 0
    // win the first contested arbitration.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            r_state    <= ST_IDLE;
            r_lastGnt  <= 1'b1;
            r_reqReady <= '0;
            r_rspValid <= '0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
            r_pSel     <= 1'b0;
            r_pEnable  <= 1'b0;
            r_pWrite   <= 1'b0;
            r_pAddr    <= '0;
            r_wrData   <= '0;
`ifdef APB_RR_TIMEOUT_EN
            r_toCnt    <= '0;
`endif
        end else begin
            r_state    <= w_nextState;
            r_lastGnt  <= w_nextLastGnt;
            r_reqReady <= w_reqReady;
            r_rspValid <= w_rspValid;
            r_rspRdata <= w_rspRdata;
            r_rspErr   <= w_rspErr;
            r_pSel     <= w_pSel;
            r_pEnable  <= w_pEnable;
            r_pWrite   <= w_pWrite;
            r_pAddr    <= w_pAddr;
            r_wrData   <= w_wrData;
`ifdef APB_RR_TIMEOUT_EN
            r_toCnt    <= w_toCnt;
`endif
        end
    end

    // Next-state and next-output logic. The w_p* values describe the APB
    // pins for the following cycle, so SETUP drives the ACCESS pin values.
    always_comb begin
        // With both valid, the one not granted last time wins.
        w_win         = (req_valid == 2'b11) ? ~r_lastGnt : req_valid[1];
        w_nextState   = r_state;
        w_nextLastGnt = r_lastGnt;
        w_reqReady    = 2'b00;
        w_rspValid    = 2'b00;
        w_rspRdata    = r_rspRdata;
        w_rspErr      = r_rspErr;
        w_pSel        = 1'b0;
        w_pEnable     = 1'b0;
        w_pWrite      = r_pWrite;
        w_pAddr       = r_pAddr;
        w_wrData      = r_wrData;
`ifdef APB_RR_TIMEOUT_EN
        w_toCnt       = r_toCnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    w_nextLastGnt = w_win;
                    w_reqReady    = w_win ? 2'b10 : 2'b01;
                    w_pSel        = 1'b1;
                    w_pWrite      = req_write[w_win];
                    w_pAddr       = w_win ? req_addr[A_WIDTH +: A_WIDTH]
                                          : req_addr[0 +: A_WIDTH];
                    w_wrData      = w_win ? req_wdata[D_WIDTH +: D_WIDTH]
                                          : req_wdata[0 +: D_WIDTH];
                    w_nextState   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_pSel      = 1'b1;
                w_pEnable   = 1'b1;
                w_nextState = ST_ACCESS;
`ifdef APB_RR_TIMEOUT_EN
                w_toCnt     = '0;
`endif
            end

            ST_ACCESS: begin
                if (p_ready) begin
                    w_rspValid  = r_lastGnt ? 2'b10 : 2'b01;
                    w_rspRdata  = r_pWrite ? '0 : rd_data;
                    w_rspErr    = p_slverr;
                    w_nextState = ST_IDLE;
                end
`ifdef APB_RR_TIMEOUT_EN
                else if (r_toCnt == TO_LAST) begin
                    w_rspValid  = r_lastGnt ? 2'b10 : 2'b01;
                    w_rspRdata  = '0;
                    w_rspErr    = 1'b1;
                    w_nextState = ST_IDLE;
                end
`endif
                else begin
                    w_pSel    = 1'b1;
                    w_pEnable = 1'b1;
`ifdef APB_RR_TIMEOUT_EN
                    w_toCnt   = r_toCnt + 8'd1;
`endif
                end
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign req_ready = r_reqReady;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;
    assign p_sel     = r_pSel;
    assign p_enable  = r_pEnable;
    assign p_write   = r_pWrite;
    assign p_addr    = r_pAddr;
    assign wr_data   = r_wrData;

endmodule
